// File: rtl/data_ram_slave_pkg.sv
// Shared constants, bus types and FSM encoding for the CPU data RAM slave.
package data_ram_slave_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef logic [31:0] data_bus_t;
  typedef logic [31:0] data_addr_bus_t;

  localparam data_bus_t ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'd0,
    DRAM_WAIT = 2'd1,
    DRAM_ACK  = 2'd2
  } dram_state_e;

  // One captured CPU request.
  typedef struct packed {
    logic           we;
    data_addr_bus_t addr;
    logic [3:0]     sel;
    data_bus_t      data;
  } dram_req_t;

endpackage

// File: rtl/data_ram_slave_if.sv
// CPU data-memory port: the CPU memory stage is the master, the RAM the slave.
interface data_ram_slave_if;
  import data_ram_slave_pkg::*;

  logic           ce;
  logic           we;
  data_addr_bus_t addr;
  logic [3:0]     sel;
  data_bus_t      data_i;
  data_bus_t      data_o;
  logic           ack;

  modport master (output ce, we, addr, sel, data_i, input data_o, ack);
  modport slave  (input ce, we, addr, sel, data_i, output data_o, ack);

endinterface

// File: rtl/data_ram_slave_array.sv
// Word storage with per-byte write lanes and a synchronous, enabled read port.
module data_ram_array
  import data_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [3:0]            lane,
  input  data_bus_t             wdata,
  output data_bus_t             rdata
);

  data_bus_t mem [2**ADDR_WIDTH];

  // Byte-lane write and registered read, both qualified by the caller's strobes.
  // NOTE: storage carries no reset so it maps onto block RAM; contents are X until written.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_ram_slave.sv
// CPU data RAM responder: accepts a load/store, stalls WAIT_STATES cycles,
// then completes with a one-cycle registered ack.
module data_ram_slave
  import data_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  data_ram_slave_if.slave  bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  dram_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dram_req_t   req_q, req_d;
  dram_req_t   live, cur;
  logic        go_ack;
  logic        rd_valid_q;
  logic        wr_en, rd_en;
  data_bus_t   rd_data;
  logic        unused_addr_bits;

  assign live = '{we: bus.we, addr: bus.addr, sel: bus.sel, data: bus.data_i};

  // In IDLE the request is still on the bus (matters when WAIT_STATES is 0);
  // afterwards only the captured copy is used.
  assign cur = (state_q == DRAM_IDLE) ? live : req_q;

  // Next-state, counter and request-capture logic.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    go_ack  = 1'b0;
    unique case (state_q)
      DRAM_IDLE: begin
        if (bus.ce == CHIP_ENABLE) begin
          req_d = live;
          cnt_d = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_d = DRAM_ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = DRAM_WAIT;
          end
        end
      end
      DRAM_WAIT: begin
        if (bus.ce != CHIP_ENABLE) begin
          state_d = DRAM_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = DRAM_ACK;
            go_ack  = 1'b1;
          end
        end
      end
      DRAM_ACK:  state_d = DRAM_IDLE;
      default:   state_d = DRAM_IDLE;
    endcase
  end

  // FSM, counter, request latches and load-valid flag.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q    <= DRAM_IDLE;
      cnt_q      <= 4'd0;
      req_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      if (rd_en) rd_valid_q <= 1'b1;
    end
  end

  // The array has no reset, so a store landing on the reset edge is blocked here.
  assign wr_en = go_ack && (cur.we == WRITE_ENABLE) && (rst != RST_ENABLE);
  assign rd_en = go_ack && (cur.we == WRITE_DISABLE);

  data_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .idx   (cur.addr[ADDR_WIDTH+1:2]),
    .lane  (cur.sel),
    .wdata (cur.data),
    .rdata (rd_data)
  );

  // High address bits alias and the byte offset is irrelevant for word access.
  assign unused_addr_bits = ^{cur.addr[31:ADDR_WIDTH+2], cur.addr[1:0]};

  assign bus.ack    = (state_q == DRAM_ACK);
  assign bus.data_o = rd_valid_q ? rd_data : ZERO_WORD;

endmodule

// File: tb/tb_data_ram_slave.sv
// Randomised bench for data_ram_slave: three instances (0, 1 and 3 wait
// states) driven from one stimulus source and checked against a word-array model.
module tb_data_ram_slave;
  import data_ram_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_q = 1'b0;
  logic        we_q = 1'b0;
  logic [31:0] addr_q = '0;
  logic [3:0]  sel_q = '0;
  logic [31:0] data_q = '0;
  int          cur = 0;

  int checks = 0;
  int errors = 0;

  int          ws [3] = '{0, 1, 3};
  logic [31:0] mdl [3][1024];
  logic [31:0] mdl_dout [3];
  int          idx_list [16];

  always #5 clk = ~clk;

  data_ram_slave_if b0 ();
  data_ram_slave_if b1 ();
  data_ram_slave_if b2 ();

  assign b0.ce = ce_q && (cur == 0);
  assign b1.ce = ce_q && (cur == 1);
  assign b2.ce = ce_q && (cur == 2);
  assign {b0.we, b1.we, b2.we} = {3{we_q}};
  assign b0.addr = addr_q;   assign b1.addr = addr_q;   assign b2.addr = addr_q;
  assign b0.sel = sel_q;     assign b1.sel = sel_q;     assign b2.sel = sel_q;
  assign b0.data_i = data_q; assign b1.data_i = data_q; assign b2.data_i = data_q;

  data_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  data_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  data_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic get_ack(input int d);
    case (d)
      0:       return b0.ack;
      1:       return b1.ack;
      default: return b2.ack;
    endcase
  endfunction

  function automatic logic [31:0] get_dout(input int d);
    case (d)
      0:       return b0.data_o;
      1:       return b1.data_o;
      default: return b2.data_o;
    endcase
  endfunction

  // Model: apply a completed request to the word array.
  task automatic model_apply(input int d, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] dt);
    int i;
    i = int'(a[11:2]);
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[d][i][8*b +: 8] = dt[8*b +: 8];
    end else begin
      mdl_dout[d] = mdl[d][i];
    end
  endtask

  // Full handshake; inputs are scrambled after acceptance to prove they are latched.
  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] dt, input string tag);
    int   lat;
    logic seen;
    @(negedge clk);
    cur = d; ce_q = 1'b1; we_q = w; addr_q = a; sel_q = s; data_q = dt;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      we_q = 1'($urandom); addr_q = $urandom; sel_q = 4'($urandom); data_q = $urandom;
      @(negedge clk);
      lat++;
      seen = get_ack(d);
    end
    ce_q = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(ws[d] + 1));
    model_apply(d, w, a, s, dt);
    if (!w) check({tag, "_rdata"}, get_dout(d), mdl_dout[d]);
    @(negedge clk);
    check({tag, "_ackpulse"}, 32'(get_ack(d)), 32'd0);
    check({tag, "_dhold"}, get_dout(d), mdl_dout[d]);
  endtask

  function automatic logic [31:0] mk_addr(input int i);
    return ($urandom & 32'hFFFF_F000) | (32'(i) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] old_w;
    for (int d = 0; d < 3; d++) mdl_dout[d] = 32'h0;
    for (int i = 0; i < 16; i++) idx_list[i] = (i * 67 + 5) % 1024;

    // Reset, then idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("idle_ack%0d", d), 32'(get_ack(d)), 32'd0);
        check($sformatf("idle_dout%0d", d), get_dout(d), 32'h0);
      end
    end

    // Full store then load, one wait state.
    txn(1, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, "st10");
    txn(1, 1'b0, 32'h0000_0010, 4'h0, 32'h0, "ld10");
    check("ld10_const", get_dout(1), 32'hDEAD_BEEF);

    // Partial store over a known word.
    txn(1, 1'b1, 32'h0000_0020, 4'hF, 32'hAABB_CCDD, "st20");
    txn(1, 1'b1, 32'h0000_0020, 4'b0101, 32'h1122_3344, "pst20");
    txn(1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, "ld20");
    check("ld20_const", get_dout(1), 32'hAA22_CC44);

    // sel=0 store modifies nothing.
    txn(1, 1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, "st20_nosel");
    txn(1, 1'b0, 32'h0000_0022, 4'h0, 32'h0, "ld20b");

    // Aliasing across the 4 KiB wrap.
    txn(1, 1'b1, 32'h0000_1000, 4'hF, 32'h5A5A_5A5A, "st1000");
    txn(1, 1'b0, 32'h0000_0000, 4'hF, 32'h0, "ld0000");
    check("alias_const", get_dout(1), 32'h5A5A_5A5A);

    // Populate every instance with known words.
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++)
        txn(d, 1'b1, mk_addr(idx_list[i]), 4'hF, $urandom, "init");

    // Aborted store, three wait states: ce dropped after two cycles.
    old_w = mdl[2][idx_list[3]];
    @(negedge clk);
    cur = 2; ce_q = 1'b1; we_q = 1'b1; addr_q = 32'(idx_list[3]) << 2; sel_q = 4'hF;
    data_q = ~old_w;
    @(negedge clk);
    @(negedge clk);
    ce_q = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_noack", 32'(get_ack(2)), 32'd0);
    end
    txn(2, 1'b0, 32'(idx_list[3]) << 2, 4'hF, 32'h0, "abort_reload");
    check("abort_old", get_dout(2), old_w);

    // Reset during WAIT of a store.
    txn(2, 1'b0, 32'(idx_list[4]) << 2, 4'hF, 32'h0, "pre_rst_ld");
    old_w = mdl[2][idx_list[5]];
    @(negedge clk);
    cur = 2; ce_q = 1'b1; we_q = 1'b1; addr_q = 32'(idx_list[5]) << 2; sel_q = 4'hF;
    data_q = ~old_w;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) mdl_dout[d] = 32'h0;
    check("rst_ack", 32'(get_ack(2)), 32'd0);
    check("rst_dout", get_dout(2), 32'h0);
    ce_q = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_ack", 32'(get_ack(2)), 32'd0);
    txn(2, 1'b0, 32'(idx_list[5]) << 2, 4'hF, 32'h0, "rst_reload");
    check("rst_nowrite", get_dout(2), old_w);

    // Back-to-back loads, zero wait states, ce held high throughout.
    @(negedge clk);
    cur = 0; ce_q = 1'b1; we_q = 1'b0; sel_q = 4'h0; addr_q = mk_addr(idx_list[0]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ack1_%0d", k), 32'(get_ack(0)), 32'd1);
      check($sformatf("b2b_data%0d", k), get_dout(0), mdl[0][idx_list[k]]);
      mdl_dout[0] = mdl[0][idx_list[k]];
      if (k < 3) addr_q = mk_addr(idx_list[k + 1]);
      else ce_q = 1'b0;
      @(negedge clk);
      check($sformatf("b2b_ack0_%0d", k), 32'(get_ack(0)), 32'd0);
    end

    // Random mixed traffic over all instances.
    for (int n = 0; n < 60; n++) begin
      int d;
      int i;
      d = $urandom_range(0, 2);
      i = idx_list[$urandom_range(0, 15)];
      txn(d, 1'($urandom), mk_addr(i), 4'($urandom), $urandom, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
